pd_hash_sequencer: RTL and testbench
====================================

Name: pd_hash_sequencer

Overview:
Controls the packet-decoder chunk datapath and the shared SHA-256 core for one 640-bit block header.
- Hashes chunk 1 once per block with hash_select=0 and commands a midstate save.
- Then hashes chunk 2 with hash_select=1 repeatedly, stepping the nonce embedded in chunk 2, until the comparator reports a hit, the nonce range is exhausted, or the host aborts.
- Sits between the packet decoder, the SHA core and the target comparator.

Parameters:
NONCE_W, 32, nonce width in bits.
NONCE_START, 0, first nonce tried for each new block.
NONCE_LAST, {NONCE_W{1'b1}}, last nonce tried; must satisfy NONCE_LAST >= NONCE_START.
TIMEOUT_CYCLES, 1024, watchdog limit in cycles per SHA pass; used only with HASH_TIMEOUT_EN.

Ports:
clk  in  1  system clock; everything is rising-edge.
n_rst  in  1  asynchronous active-low reset.
new_block  in  1  one-cycle pulse: chunk_1/chunk_2 header registers hold a new block.
abort  in  1  level; stops the search.
hash_done  in  1  one-cycle pulse from SHA core: current pass complete.
hash_hit  in  1  comparator result for the chunk-2 digest; valid in the cycle after hash_done.
hash_select  out  2  selects the chunk decoder source: 0 = chunk 1, 1 = padded chunk 2. Values 2 and 3 are never driven.
hash_start  out  1  one-cycle pulse: SHA core starts a pass on data_to_hash.
midstate_load  out  1  one-cycle pulse: SHA core latches its state as the midstate.
nonce  out  NONCE_W  nonce inserted into chunk 2.
busy  out  1  high in every state except IDLE.
nonce_found  out  1  one-cycle pulse; nonce holds the winning value.
exhausted  out  1  one-cycle pulse: NONCE_LAST tried with no hit.
timeout_err  out  1  one-cycle pulse when the watchdog fires; tied 0 when the macro is off.

Behaviour:
- Reset (n_rst=0, async): state=IDLE; hash_select=0, hash_start=0, midstate_load=0, busy=0, nonce_found=0, exhausted=0, timeout_err=0; nonce=NONCE_START.
- All outputs are registered or Moore-decoded from state; there are no combinational paths from inputs to outputs.
- States: IDLE, C1_START, C1_WAIT, MID_LOAD, C2_START, C2_WAIT, CHECK.
- IDLE: new_block -> C1_START; nonce<=NONCE_START.
- C1_START: hash_select=0, hash_start=1 -> C1_WAIT.
- C1_WAIT: hash_select=0; hash_done -> MID_LOAD.
- MID_LOAD: midstate_load=1, hash_select<=1 -> C2_START.
- C2_START: hash_select=1, hash_start=1 -> C2_WAIT.
- C2_WAIT: hash_done -> CHECK.
- CHECK: sample hash_hit.
  - hit: nonce_found pulse in the next cycle -> IDLE; nonce retained.
  - no hit and nonce==NONCE_LAST: exhausted pulse -> IDLE.
  - otherwise: nonce<=nonce+1 -> C2_START.
- hash_select stays 1 from MID_LOAD through CHECK and returns to 0 on entry to IDLE.
- Latency: new_block at cycle N gives hash_start at N+1. Each C2 iteration is 3 cycles plus SHA latency (C2_START, C2_WAIT, CHECK).
- Priority when inputs coincide: abort > new_block > hash_done.
  - abort in any state -> IDLE next cycle; no hash_start, nonce_found or exhausted is issued; nonce holds its value.
  - new_block while busy (and abort=0) restarts at C1_START with nonce=NONCE_START; a pending hash_done is discarded.
- hash_done outside C1_WAIT/C2_WAIT is ignored.
- nonce never wraps: the increment is suppressed at NONCE_LAST. NONCE_START==NONCE_LAST gives exactly one chunk-2 pass.
- Reset asserted mid-search returns all outputs to their reset values immediately.

Optional Feature:
HASH_TIMEOUT_EN
- Defined: a counter clears on entry to C1_WAIT/C2_WAIT and increments each cycle in those states. When it reaches TIMEOUT_CYCLES without hash_done, timeout_err pulses and the FSM retries the pass by returning to C1_START or C2_START; nonce is unchanged.
- Undefined: no counter is built, timeout_err is constant 0, and the WAIT states wait indefinitely.

Test Plan:
- Reset then new_block; SHA model returns done 64 cycles after start, hash_hit=0; NONCE_START=0, NONCE_LAST=3 -> one hash_start with select 0, one midstate_load, four chunk-2 starts with nonce 0,1,2,3, then exhausted pulse, busy=0, nonce=3.
- Same setup, hash_hit=1 on nonce 2 -> nonce_found pulse with nonce=2, no exhausted, no further hash_start, hash_select back to 0.
- abort asserted in the same cycle as hash_done in C2_WAIT at nonce 1 -> IDLE next cycle, no CHECK, nonce stays 1, no pulses.
- new_block pulse during C2_WAIT at nonce 5 -> hash_start with hash_select=0 next cycle, nonce=0, midstate_load repeated.
- n_rst pulled low asynchronously mid-C1_WAIT -> all outputs are at reset values before the next clk edge; no hash_start after release until new_block.
- With HASH_TIMEOUT_EN and TIMEOUT_CYCLES=16, withhold hash_done in C2_WAIT -> timeout_err after 16 cycles and hash_start reissued with the same nonce.

Source files
------------

// File: rtl/pd_hash_sequencer_if.sv
// Handshake bundle between the hash sequencer, packet decoder, SHA-256 core and target comparator.
interface pd_hash_sequencer_if #(
  parameter int unsigned NONCE_W = 32
);
  logic               new_block;
  logic               abort;
  logic               hash_done;
  logic               hash_hit;
  logic [1:0]         hash_select;
  logic               hash_start;
  logic               midstate_load;
  logic [NONCE_W-1:0] nonce;
  logic               busy;
  logic               nonce_found;
  logic               exhausted;
  logic               timeout_err;

  modport master (
    output new_block, abort, hash_done, hash_hit,
    input  hash_select, hash_start, midstate_load, nonce,
    input  busy, nonce_found, exhausted, timeout_err
  );

  modport slave (
    input  new_block, abort, hash_done, hash_hit,
    output hash_select, hash_start, midstate_load, nonce,
    output busy, nonce_found, exhausted, timeout_err
  );
endinterface

// File: rtl/pd_hash_sequencer.sv
// Chunk-1 / midstate / chunk-2 nonce-search sequencer for one 640-bit block header.
// Optional per-pass watchdog enabled by defining HASH_TIMEOUT_EN.
module pd_hash_sequencer #(
  parameter int unsigned        NONCE_W        = 32,
  parameter logic [NONCE_W-1:0] NONCE_START    = '0,
  parameter logic [NONCE_W-1:0] NONCE_LAST     = '1,
  parameter int unsigned        TIMEOUT_CYCLES = 1024
) (
  input logic               clk,
  input logic               n_rst,
  pd_hash_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_C1_START,
    S_C1_WAIT,
    S_MID_LOAD,
    S_C2_START,
    S_C2_WAIT,
    S_CHECK
  } state_t;

  if (NONCE_LAST < NONCE_START || TIMEOUT_CYCLES == 0) begin : g_bad_params
    $error("pd_hash_sequencer: NONCE_LAST < NONCE_START or TIMEOUT_CYCLES == 0");
  end

  state_t             state_q, state_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic               found_q, found_d;
  logic               exh_q, exh_d;

`ifdef HASH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
  logic             cnt_expired;

  assign cnt_expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d = state_q;
    nonce_d = nonce_q;
    found_d = 1'b0;
    exh_d   = 1'b0;
`ifdef HASH_TIMEOUT_EN
    tmo_d   = 1'b0;
    // START states always precede WAIT, so the count is already zero on entry.
    cnt_d   = (state_q == S_C1_WAIT || state_q == S_C2_WAIT) ? cnt_q + 1'b1 : '0;
`endif
    if (bus.abort) begin
      state_d = S_IDLE;
    end else if (bus.new_block) begin
      state_d = S_C1_START;
      nonce_d = NONCE_START;
    end else begin
      case (state_q)
        S_C1_START: state_d = S_C1_WAIT;
        S_C1_WAIT: begin
          if (bus.hash_done) begin
            state_d = S_MID_LOAD;
          end
`ifdef HASH_TIMEOUT_EN
          else if (cnt_expired) begin
            state_d = S_C1_START;
            tmo_d   = 1'b1;
          end
`endif
        end
        S_MID_LOAD: state_d = S_C2_START;
        S_C2_START: state_d = S_C2_WAIT;
        S_C2_WAIT: begin
          if (bus.hash_done) begin
            state_d = S_CHECK;
          end
`ifdef HASH_TIMEOUT_EN
          else if (cnt_expired) begin
            state_d = S_C2_START;
            tmo_d   = 1'b1;
          end
`endif
        end
        S_CHECK: begin
          if (bus.hash_hit) begin
            found_d = 1'b1;
            state_d = S_IDLE;
          end else if (nonce_q == NONCE_LAST) begin
            exh_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            nonce_d = nonce_q + 1'b1;
            state_d = S_C2_START;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      nonce_q <= NONCE_START;
      found_q <= 1'b0;
      exh_q   <= 1'b0;
`ifdef HASH_TIMEOUT_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      nonce_q <= nonce_d;
      found_q <= found_d;
      exh_q   <= exh_d;
`ifdef HASH_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  // hash_select is a pure state decode: 1 from MID_LOAD through CHECK.
  assign bus.hash_select   = {1'b0, (state_q == S_MID_LOAD || state_q == S_C2_START ||
                                     state_q == S_C2_WAIT  || state_q == S_CHECK)};
  assign bus.hash_start    = (state_q == S_C1_START) || (state_q == S_C2_START);
  assign bus.midstate_load = (state_q == S_MID_LOAD);
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.nonce         = nonce_q;
  assign bus.nonce_found   = found_q;
  assign bus.exhausted     = exh_q;
`ifdef HASH_TIMEOUT_EN
  assign bus.timeout_err   = tmo_q;
`else
  assign bus.timeout_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pd_hash_sequencer.sv
// Self-checking bench for pd_hash_sequencer: table-driven search scenarios with a hash_start scoreboard,
// plus hand-driven abort, restart, async-reset and (with HASH_TIMEOUT_EN) watchdog sequences.
module tb_pd_hash_sequencer;
  localparam int unsigned W   = 8;
  localparam int unsigned LAT = 64;
  localparam int unsigned TMO = 16;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  pd_hash_sequencer_if #(.NONCE_W(W)) a_if ();
  pd_hash_sequencer_if #(.NONCE_W(W)) b_if ();

  logic a_nb = 1'b0, a_ab = 1'b0, m_done = 1'b0, m_hit = 1'b0, t_done = 1'b0, t_hit = 1'b0;
  logic b_nb = 1'b0, b_ab = 1'b0, b_done = 1'b0, b_hit = 1'b0;

  assign a_if.new_block = a_nb;
  assign a_if.abort     = a_ab;
  assign a_if.hash_done = m_done | t_done;
  assign a_if.hash_hit  = m_hit | t_hit;
  assign b_if.new_block = b_nb;
  assign b_if.abort     = b_ab;
  assign b_if.hash_done = b_done;
  assign b_if.hash_hit  = b_hit;

  pd_hash_sequencer #(
    .NONCE_W(W), .NONCE_START(8'd0), .NONCE_LAST(8'd3), .TIMEOUT_CYCLES(TMO)
  ) dut_a (
    .clk(clk), .n_rst(n_rst), .bus(a_if)
  );

  pd_hash_sequencer #(
    .NONCE_W(W), .NONCE_START(8'd0), .NONCE_LAST(8'd7), .TIMEOUT_CYCLES(TMO)
  ) dut_b (
    .clk(clk), .n_rst(n_rst), .bus(b_if)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Scoreboard of expected hash_start events on DUT A
  typedef struct packed {
    logic [1:0]   sel;
    logic [W-1:0] nonce;
  } start_t;
  start_t exp_q[$];

  int mid_cnt = 0, found_cnt = 0, exh_cnt = 0, tmo_cnt = 0, tmo_total = 0, start_cnt = 0;
  logic [W-1:0] found_nonce = '0;

  always @(negedge clk) begin
    if (n_rst) begin
      if (a_if.hash_start) begin
        start_t e;
        start_cnt++;
        chk("start_expected", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("start_sel", a_if.hash_select, e.sel);
          chk("start_nonce", a_if.nonce, e.nonce);
        end
      end
      if (a_if.midstate_load) mid_cnt++;
      if (a_if.nonce_found) begin
        found_cnt++;
        found_nonce = a_if.nonce;
      end
      if (a_if.exhausted) exh_cnt++;
      if (a_if.timeout_err) begin
        tmo_cnt++;
        tmo_total++;
      end
    end
  end

  // SHA core + comparator model for DUT A: done LAT cycles after start, hit on the chosen nonce
  logic         model_en = 1'b0;
  int           hit_nonce = -1;
  int           sha_cnt = 0;
  logic         hit_pend = 1'b0;
  logic [W-1:0] cur_n = '0;

  initial forever begin
    @(negedge clk);
    m_done = 1'b0;
    m_hit  = 1'b0;
    if (!model_en || !n_rst) begin
      sha_cnt  = 0;
      hit_pend = 1'b0;
    end else begin
      if (hit_pend) begin
        m_hit    = (hit_nonce == int'(cur_n));
        hit_pend = 1'b0;
      end
      if (sha_cnt > 0) begin
        sha_cnt--;
        if (sha_cnt == 0) begin
          m_done   = 1'b1;
          hit_pend = 1'b1;
        end
      end
      if (a_if.hash_start) begin
        sha_cnt = LAT;
        cur_n   = a_if.nonce;
      end
    end
  end

  task automatic clr_counts();
    mid_cnt = 0; found_cnt = 0; exh_cnt = 0; tmo_cnt = 0; start_cnt = 0;
  endtask

  task automatic push_start(input logic [1:0] sel, input int n);
    start_t e;
    e.sel   = sel;
    e.nonce = W'(n);
    exp_q.push_back(e);
  endtask

  task automatic a_wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_if.hash_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic b_wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b_if.hash_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    int hit_nonce;
    int exp_c2;
    int exp_found;
    int exp_exh;
    int exp_nonce;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=%0t expected=finish", $time);
    $fatal(1, "bench timed out");
  end

  initial begin
    bit ok;
    int cyc;

    vecs[0] = '{hit_nonce: -1, exp_c2: 4, exp_found: 0, exp_exh: 1, exp_nonce: 3};
    vecs[1] = '{hit_nonce:  2, exp_c2: 3, exp_found: 1, exp_exh: 0, exp_nonce: 2};
    vecs[2] = '{hit_nonce:  0, exp_c2: 1, exp_found: 1, exp_exh: 0, exp_nonce: 0};
    vecs[3] = '{hit_nonce:  3, exp_c2: 4, exp_found: 1, exp_exh: 0, exp_nonce: 3};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", a_if.busy, 0);
    chk("rst_start", a_if.hash_start, 0);
    chk("rst_sel", a_if.hash_select, 0);
    chk("rst_mid", a_if.midstate_load, 0);
    chk("rst_nonce", a_if.nonce, 0);
    chk("rst_pulses", {a_if.nonce_found, a_if.exhausted, a_if.timeout_err}, 0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      clr_counts();
      exp_q.delete();
      hit_nonce = vecs[v].hit_nonce;
      model_en  = 1'b1;
      push_start(2'd0, 0);
      for (int n = 0; n < vecs[v].exp_c2; n++) push_start(2'd1, n);
      a_nb = 1'b1;
      @(negedge clk);
      a_nb = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        @(negedge clk);
        if (!a_if.busy) begin
          ok = 1'b1;
          break;
        end
      end
      chk("vec_done", ok, 1);
      repeat (3) @(negedge clk);
      chk("vec_pending_starts", exp_q.size(), 0);
      chk("vec_midstate", mid_cnt, 1);
      chk("vec_found", found_cnt, vecs[v].exp_found);
      chk("vec_exhausted", exh_cnt, vecs[v].exp_exh);
      chk("vec_nonce", a_if.nonce, vecs[v].exp_nonce);
      chk("vec_sel_idle", a_if.hash_select, 0);
      if (vecs[v].exp_found != 0) chk("vec_found_nonce", found_nonce, vecs[v].exp_nonce);
      model_en = 1'b0;
      repeat (2) @(negedge clk);
    end

    // abort coinciding with hash_done in C2_WAIT at nonce 1
    clr_counts();
    exp_q.delete();
    push_start(2'd0, 0);
    push_start(2'd1, 0);
    push_start(2'd1, 1);
    a_nb = 1'b1;
    @(negedge clk);
    a_nb = 1'b0;
    chk("nb_latency_start", a_if.hash_start, 1);
    chk("nb_latency_sel", a_if.hash_select, 0);
    repeat (3) @(negedge clk);
    t_done = 1'b1;
    @(negedge clk);
    t_done = 1'b0;
    a_wait_start(ok);
    chk("abort_c2_start0", ok, 1);
    repeat (2) @(negedge clk);
    t_done = 1'b1;
    @(negedge clk);
    t_done = 1'b0;
    a_wait_start(ok);
    chk("abort_c2_start1", ok, 1);
    repeat (2) @(negedge clk);
    t_done = 1'b1;
    a_ab   = 1'b1;
    @(negedge clk);
    t_done = 1'b0;
    a_ab   = 1'b0;
    chk("abort_busy", a_if.busy, 0);
    chk("abort_nonce", a_if.nonce, 1);
    chk("abort_sel", a_if.hash_select, 0);
    repeat (10) @(negedge clk);
    chk("abort_no_pulses", found_cnt + exh_cnt, 0);
    chk("abort_no_restart", start_cnt, 3);

    // new_block restart during C2_WAIT at nonce 5 (DUT B)
    b_nb = 1'b1;
    @(negedge clk);
    b_nb = 1'b0;
    repeat (2) @(negedge clk);
    b_done = 1'b1;
    @(negedge clk);
    b_done = 1'b0;
    for (int n = 0; n < 5; n++) begin
      b_wait_start(ok);
      chk("b_start_seen", ok, 1);
      chk("b_nonce_step", b_if.nonce, n);
      repeat (2) @(negedge clk);
      b_done = 1'b1;
      @(negedge clk);
      b_done = 1'b0;
    end
    b_wait_start(ok);
    chk("b_nonce5", b_if.nonce, 5);
    @(negedge clk);
    b_nb = 1'b1;
    @(negedge clk);
    b_nb = 1'b0;
    chk("b_restart_start", b_if.hash_start, 1);
    chk("b_restart_sel", b_if.hash_select, 0);
    chk("b_restart_nonce", b_if.nonce, 0);
    repeat (2) @(negedge clk);
    b_done = 1'b1;
    @(negedge clk);
    b_done = 1'b0;
    chk("b_restart_midstate", b_if.midstate_load, 1);
    chk("b_restart_mid_sel", b_if.hash_select, 1);
    b_ab = 1'b1;
    @(negedge clk);
    b_ab = 1'b0;

    // async reset in C1_WAIT
    clr_counts();
    exp_q.delete();
    push_start(2'd0, 0);
    a_nb = 1'b1;
    @(negedge clk);
    a_nb = 1'b0;
    @(negedge clk);
    chk("c1wait_busy", a_if.busy, 1);
    #2 n_rst = 1'b0;
    #1;
    chk("arst_busy", a_if.busy, 0);
    chk("arst_start", a_if.hash_start, 0);
    chk("arst_sel", a_if.hash_select, 0);
    chk("arst_nonce", a_if.nonce, 0);
    exp_q.delete();
    @(negedge clk);
    n_rst = 1'b1;
    start_cnt = 0;
    repeat (20) @(negedge clk);
    chk("arst_no_start", start_cnt, 0);
    chk("arst_idle", a_if.busy, 0);

`ifdef HASH_TIMEOUT_EN
    // withheld hash_done in C2_WAIT: watchdog retries the same nonce
    clr_counts();
    exp_q.delete();
    push_start(2'd0, 0);
    push_start(2'd1, 0);
    push_start(2'd1, 0);
    a_nb = 1'b1;
    @(negedge clk);
    a_nb = 1'b0;
    repeat (2) @(negedge clk);
    t_done = 1'b1;
    @(negedge clk);
    t_done = 1'b0;
    a_wait_start(ok);
    chk("tmo_c2_start", ok, 1);
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cyc++;
      if (a_if.timeout_err) break;
    end
    chk("tmo_cycles", cyc, TMO + 1);
    chk("tmo_restart", a_if.hash_start, 1);
    chk("tmo_nonce", a_if.nonce, 0);
    a_ab = 1'b1;
    @(negedge clk);
    a_ab = 1'b0;
    repeat (2) @(negedge clk);
    chk("tmo_pending_starts", exp_q.size(), 0);
`else
    chk("timeout_never", tmo_total, 0);
    chk("timeout_tied", a_if.timeout_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
